dmem_responder: RTL and testbench

Data-memory responder for the pipelined RV64 core: the slave end of the core's load/store port. It accepts one load or store request at a time over a valid/ready handshake, waits a programmable access latency, then returns read data or a write acknowledgement over a second valid/ready handshake. It replaces the zero-latency data memory behind the EX/MEM stage, so a stalling memory interface can be exercised.

---
 rtl/dmem_pkg.sv | 20 ++
 rtl/dmem_array.sv | 31 +++
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types, widths and the access-legality check for the data-memory responder.
package dmem_pkg;

    localparam int XLEN   = 64;
    localparam int STRB_W = XLEN / 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // An access is illegal when it is not doubleword aligned or falls past the last word.
    function automatic logic err_of(input logic [XLEN-1:0] addr, input int unsigned depth);
        logic [XLEN-1:0] limit;
        limit  = XLEN'(depth) << 3;
        err_of = (addr[2:0] != 3'd0) || (addr >= limit);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Doubleword storage: synchronous byte-strobed write, asynchronous read, no reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    input  logic [STRB_W-1:0] strb,
    output logic [XLEN-1:0]   rdata
);

    logic [XLEN-1:0] mem_r [DEPTH_WORDS];

    // Commit only the enabled byte lanes of the addressed word.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (strb[i]) begin
                    mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/dmem_responder.sv
// Load/store slave with a programmable access latency and valid/ready on both request and response.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 64,
    parameter int LATENCY     = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [XLEN-1:0]   req_addr,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [STRB_W-1:0] req_strb,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [XLEN-1:0]   rsp_rdata,
    output logic              rsp_err
);

    localparam int         AW       = $clog2(DEPTH_WORDS);
    localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

    state_t              state_r, state_next_s;
    logic [3:0]          cnt_r;
    logic                req_ready_r, rsp_valid_r, rsp_err_r;
    logic [XLEN-1:0]     rsp_rdata_r;
    logic                write_r;
    logic [XLEN-1:0]     addr_r, wdata_r;
    logic [STRB_W-1:0]   strb_r;

    logic                accept_s, finish_s, handshake_s, err_s, we_s;
    logic [XLEN-1:0]     rd_word_s;

    assign accept_s    = req_valid && req_ready_r;
    assign finish_s    = (state_r == BUSY) && (cnt_r == 4'd0);
    assign handshake_s = rsp_valid_r && rsp_ready;
    assign err_s       = err_of(addr_r, DEPTH_WORDS);
    // The commit happens on the BUSY->RESP edge, so a reset while still in BUSY drops the store.
    assign we_s        = finish_s && write_r && !err_s;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk   (clk),
        .we    (we_s),
        .addr  (addr_r[AW+2:3]),
        .wdata (wdata_r),
        .strb  (strb_r),
        .rdata (rd_word_s)
    );

    // Next-state logic for the single-outstanding-request FSM.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) state_next_s = BUSY;
                else          state_next_s = IDLE;
            end
            BUSY: begin
                if (cnt_r == 4'd0) state_next_s = RESP;
                else               state_next_s = BUSY;
            end
            RESP: begin
                if (handshake_s) state_next_s = IDLE;
                else             state_next_s = RESP;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // State, latency counter and the registered handshake flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            req_ready_r <= 1'b0;
            rsp_valid_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            req_ready_r <= (state_next_s == IDLE);
            rsp_valid_r <= (state_next_s == RESP);
            if (accept_s) begin
                cnt_r <= CNT_INIT;
            end else if ((state_r == BUSY) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    // Request capture on acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_r <= 1'b0;
            addr_r  <= {XLEN{1'b0}};
            wdata_r <= {XLEN{1'b0}};
            strb_r  <= {STRB_W{1'b0}};
        end else if (accept_s) begin
            write_r <= req_write;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
            strb_r  <= req_strb;
        end
    end

    // Response payload is loaded once on entry to RESP and then held until the handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_rdata_r <= {XLEN{1'b0}};
            rsp_err_r   <= 1'b0;
        end else if (finish_s) begin
            rsp_rdata_r <= (write_r || err_s) ? {XLEN{1'b0}} : rd_word_s;
            rsp_err_r   <= err_s;
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_rdata = rsp_rdata_r;
    assign rsp_err   = rsp_err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a LATENCY=2 and a LATENCY=4 instance, table-driven transactions plus corner sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid_a = 1'b0, req_valid_b = 1'b0;
    logic        req_write = 1'b0;
    logic [63:0] req_addr = 64'd0, req_wdata = 64'd0;
    logic [7:0]  req_strb = 8'd0;
    logic        rsp_ready = 1'b0;

    logic        req_ready_a, rsp_valid_a, rsp_err_a;
    logic [63:0] rsp_rdata_a;
    logic        req_ready_b, rsp_valid_b, rsp_err_b;
    logic [63:0] rsp_rdata_b;

    bit          sel = 1'b0;
    logic        cur_req_ready, cur_rsp_valid, cur_rsp_err;
    logic [63:0] cur_rsp_rdata;

    int passes = 0;
    int checks = 0;

    typedef struct {
        logic [63:0] rdata;
        logic        err;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [7:0]  strb;
        logic [63:0] exp_rdata;
        logic        exp_err;
    } vec_t;
    vec_t vecs[14];

    always #5 clk = ~clk;

    assign cur_req_ready = sel ? req_ready_b : req_ready_a;
    assign cur_rsp_valid = sel ? rsp_valid_b : rsp_valid_a;
    assign cur_rsp_err   = sel ? rsp_err_b   : rsp_err_a;
    assign cur_rsp_rdata = sel ? rsp_rdata_b : rsp_rdata_a;

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_a), .req_ready(req_ready_a), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_a), .rsp_err(rsp_err_a)
    );

    dmem_responder #(.DEPTH_WORDS(64), .LATENCY(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata_b), .rsp_err(rsp_err_b)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic wait_ready();
        int w = 0;
        while (!cur_req_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        check("req_ready_wait", {63'd0, cur_req_ready}, 64'd1);
    endtask

    task automatic drive_req(input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                             input logic [7:0] strb);
        req_write = wr; req_addr = addr; req_wdata = wdata; req_strb = strb;
        if (sel) req_valid_b = 1'b1;
        else     req_valid_a = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        req_addr = 64'hFFFF_FFFF_FFFF_FFFF;
        req_wdata = 64'hBAD0_BAD0_BAD0_BAD0;
    endtask

    // One full transaction: accept, measure latency, optional stall, handshake.
    task automatic do_txn(input bit s, input logic wr, input logic [63:0] addr, input logic [63:0] wdata,
                          input logic [7:0] strb, input logic [63:0] exp_rdata, input logic exp_err,
                          input int stall);
        exp_t e, got;
        int n = 0;
        int lat;
        logic [63:0] hold_rdata;
        logic        hold_err;
        sel = s;
        lat = s ? 4 : 2;
        @(negedge clk);
        wait_ready();
        e.rdata = exp_rdata;
        e.err   = exp_err;
        exp_q.push_back(e);
        drive_req(wr, addr, wdata, strb);
        check("busy_req_ready", {63'd0, cur_req_ready}, 64'd0);
        while (!cur_rsp_valid && n < 40) begin
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        check("latency", 64'(n), 64'(lat));
        got = exp_q.pop_front();
        check("rsp_rdata", cur_rsp_rdata, got.rdata);
        check("rsp_err", {63'd0, cur_rsp_err}, {63'd0, got.err});
        hold_rdata = cur_rsp_rdata;
        hold_err   = cur_rsp_err;
        for (int k = 0; k < stall; k++) begin
            @(negedge clk);
            check("stall_valid", {63'd0, cur_rsp_valid}, 64'd1);
            check("stall_rdata", cur_rsp_rdata, hold_rdata);
            check("stall_err", {63'd0, cur_rsp_err}, {63'd0, hold_err});
            check("stall_req_ready", {63'd0, cur_req_ready}, 64'd0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        check("post_hs_valid", {63'd0, cur_rsp_valid}, 64'd0);
        check("post_hs_req_ready", {63'd0, cur_req_ready}, 64'd1);
    endtask

    initial begin
        vecs[0]  = '{1'b1, 64'h10,  64'h1122334455667788, 8'hFF, 64'h0, 1'b0};
        vecs[1]  = '{1'b0, 64'h10,  64'h0,                8'h00, 64'h1122334455667788, 1'b0};
        vecs[2]  = '{1'b1, 64'h18,  64'h0,                8'hFF, 64'h0, 1'b0};
        vecs[3]  = '{1'b1, 64'h18,  64'hAAAAAAAAAAAAAAAA, 8'h0F, 64'h0, 1'b0};
        vecs[4]  = '{1'b0, 64'h18,  64'h0,                8'hFF, 64'h00000000AAAAAAAA, 1'b0};
        vecs[5]  = '{1'b0, 64'h13,  64'h0,                8'h00, 64'h0, 1'b1};
        vecs[6]  = '{1'b1, 64'h1F8, 64'h5A5A5A5A5A5A5A5A, 8'hFF, 64'h0, 1'b0};
        vecs[7]  = '{1'b1, 64'h200, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1};
        vecs[8]  = '{1'b0, 64'h1F8, 64'h0,                8'h00, 64'h5A5A5A5A5A5A5A5A, 1'b0};
        vecs[9]  = '{1'b1, 64'h20,  64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0};
        vecs[10] = '{1'b1, 64'h20,  64'hFFFFFFFFFFFFFFFF, 8'hF0, 64'h0, 1'b0};
        vecs[11] = '{1'b1, 64'h21,  64'h0,                8'hFF, 64'h0, 1'b1};
        vecs[12] = '{1'b0, 64'h20,  64'h0,                8'h00, 64'hFFFFFFFF89ABCDEF, 1'b0};
        vecs[13] = '{1'b0, 64'h8000000000000010, 64'h0,   8'h00, 64'h0, 1'b1};

        // Reset phase: outputs must be zero throughout, req_ready rises one edge after release.
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_req_ready_a", {63'd0, req_ready_a}, 64'd0);
            check("rst_rsp_valid_a", {63'd0, rsp_valid_a}, 64'd0);
            check("rst_rdata_a", rsp_rdata_a, 64'd0);
            check("rst_err_b", {63'd0, rsp_err_b}, 64'd0);
        end
        rst_n = 1'b1;
        #1;
        check("rel_req_ready_before_edge", {63'd0, req_ready_a}, 64'd0);
        @(negedge clk);
        check("rel_req_ready_a", {63'd0, req_ready_a}, 64'd1);
        check("rel_req_ready_b", {63'd0, req_ready_b}, 64'd1);
        check("rel_rsp_valid_a", {63'd0, rsp_valid_a}, 64'd0);

        foreach (vecs[i])
            do_txn(1'b0, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb,
                   vecs[i].exp_rdata, vecs[i].exp_err, 0);

        // Backpressure: response held for 5 cycles with rsp_ready low.
        do_txn(1'b0, 1'b0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 5);

        // Longer-latency instance: establish known contents at 0x20.
        do_txn(1'b1, 1'b1, 64'h20, 64'hCAFEF00DCAFEF00D, 8'hFF, 64'h0, 1'b0, 0);
        do_txn(1'b1, 1'b0, 64'h20, 64'h0, 8'h00, 64'hCAFEF00DCAFEF00D, 1'b0, 2);

        // Reset two cycles after a store is accepted: the store must never commit.
        sel = 1'b1;
        @(negedge clk);
        wait_ready();
        drive_req(1'b1, 64'h20, 64'h000000000000DEAD, 8'hFF);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_rsp_valid", {63'd0, rsp_valid_b}, 64'd0);
        check("midrst_req_ready", {63'd0, req_ready_b}, 64'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            check("no_rsp_after_rst", {63'd0, rsp_valid_b}, 64'd0);
        end
        do_txn(1'b1, 1'b0, 64'h20, 64'h0, 8'h00, 64'hCAFEF00DCAFEF00D, 1'b0, 0);
        // Committed stores on the other instance survive the reset.
        do_txn(1'b0, 1'b0, 64'h10, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
